fetch_unit: RTL

Instruction fetch stage of the single-cycle RV32I core, directly upstream of the control unit. Owns the program counter, issues one-outstanding-request fetches to instruction memory over a valid/ready handshake, and registers the returned instruction. Presents `instr`, `pc`, and the pre-sliced `opcode`/`funct3`/`funct7` fields to decode. Accepts branch/jump redirects from execute and honours a downstream stall.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// RV32I fetch: one outstanding imem request, 3 cycles/instr at zero wait; stall holds instr, redirect wins.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and halts until reset.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
`ifdef FETCH_MISALIGN_CHECK_EN
      , S_HALT
`endif
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state_q;
   logic [31:0] fpc_q;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        req_q;
   logic        ivld_q;
   logic        drop_q;
   logic        fault_q;
   logic [31:0] tgt_d;
   logic        accept;
   logic        misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign tgt_d    = redirect_pc;
   assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
   assign tgt_d    = redirect_pc & 32'hFFFF_FFFC;
   assign misalign = 1'b0;
`endif

   // req_q is low for the first cycle out of reset, so nothing is accepted then
   assign accept = (state_q == S_REQ) && req_q && imem_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         fpc_q   <= RESET_PC;
         instr_q <= NOP;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         ivld_q  <= 1'b0;
         drop_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            S_REQ: begin
               if (redirect) begin
                  fpc_q <= tgt_d;
               end
               if (accept) begin
                  drop_q  <= redirect;
                  req_q   <= 1'b0;
                  state_q <= S_WAIT;
               end else begin
                  req_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (redirect) begin
                  fpc_q <= tgt_d;
                  if (imem_rsp_valid) begin
                     drop_q  <= 1'b0;
                     req_q   <= 1'b1;
                     state_q <= S_REQ;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (drop_q) begin
                     drop_q  <= 1'b0;
                     req_q   <= 1'b1;
                     state_q <= S_REQ;
                  end else begin
                     instr_q <= imem_rsp_data;
                     pc_q    <= fpc_q;
                     ivld_q  <= 1'b1;
                     state_q <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (redirect || !stall) begin
                  fpc_q   <= redirect ? tgt_d : fpc_q + 32'd4;
                  ivld_q  <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            default: begin
               req_q  <= 1'b0;
               ivld_q <= 1'b0;
            end
         endcase
`ifdef FETCH_MISALIGN_CHECK_EN
         // later assignments override whatever the state case decided
         if (misalign && (state_q != S_HALT)) begin
            fault_q <= 1'b1;
            req_q   <= 1'b0;
            ivld_q  <= 1'b0;
            state_q <= S_HALT;
         end
`endif
      end
   end

   assign imem_req_valid = req_q;
   assign imem_addr      = fpc_q;
   assign instr_valid    = ivld_q;
   assign instr          = instr_q;
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign opcode         = instr_q[6:0];
   assign funct3         = instr_q[14:12];
   assign funct7         = instr_q[31:25];
`ifdef FETCH_MISALIGN_CHECK_EN
   assign fetch_fault    = fault_q;
`else
   assign fetch_fault    = 1'b0;
`endif

endmodule
